// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, fixed-latency memory between the fetch port (i_*)
// and the data port (d_*). One access runs at a time. The mem_* outputs stay
// frozen for the whole access, and each completion is a one-cycle ready pulse.
//
// Handshake: a port raises req (level) and holds it, with its address and
// data stable, until it sees ready high for one cycle. It drops req on the
// following edge. A port's request is therefore ignored during its own ready
// cycle. i_cancel is a pulse that discards a pending or in-flight fetch.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   i_req/i_addr/i_cancel       fetch request, address, flush pulse
//   i_rdata/i_ready             fetched word, completion pulse
//   d_req/d_wr/d_addr/d_wdata   data request (load/store)
//   d_rdata/d_ready             load data, completion pulse
//   mem_en/mem_wr/mem_addr/mem_wdata/mem_rdata   memory macro side
//   stall_if/stall_mem          combinational pipeline stall requests
//   conflict_cnt                saturating count of cycles with both ports waiting
//   dbg_state                   current FSM state (0 IDLE, 1 DATA, 2 INST)
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_cancel,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [15:0]       conflict_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cancelled_q, cancelled_d;
  logic              last_data_q, last_data_d;   // 1: last completed access was DATA
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic [15:0]       conflict_q, conflict_d;

  // A waiting port is exactly an eligible port, so the stall terms double
  // as the arbitration eligibility terms.
  logic i_elig, d_elig;
  assign i_elig    = i_req & ~i_ready_q & ~i_cancel;
  assign d_elig    = d_req & ~d_ready_q;
  assign stall_if  = i_elig;
  assign stall_mem = d_elig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cancelled_q <= 1'b0;
      last_data_q <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      conflict_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cancelled_q <= cancelled_d;
      last_data_q <= last_data_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      conflict_q  <= conflict_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cancelled_d = cancelled_q;
    last_data_d = last_data_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    conflict_d  = conflict_q;

    case (state_q)
      ST_IDLE: begin
        // DATA normally wins. A waiting fetch goes first right after a
        // completed DATA access, so the ports alternate under contention.
        if (i_elig && (!d_elig || last_data_q)) begin
          state_d     = ST_INST;
          mem_en_d    = 1'b1;
          mem_wr_d    = 1'b0;
          mem_addr_d  = i_addr;
          cnt_d       = 4'd0;
          cancelled_d = 1'b0;
        end else if (d_elig) begin
          state_d     = ST_DATA;
          mem_en_d    = 1'b1;
          mem_wr_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          cnt_d       = 4'd0;
          cancelled_d = 1'b0;
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          if (!mem_wr_q) d_rdata_d = mem_rdata;
          d_ready_d   = 1'b1;
          last_data_d = 1'b1;
          mem_en_d    = 1'b0;
          mem_wr_d    = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      ST_INST: begin
        cnt_d = cnt_q + 4'd1;
        // The memory cannot be aborted. A flushed fetch runs to the end and
        // is then silently dropped, including a flush in its final cycle.
        if (i_cancel) cancelled_d = 1'b1;
        if (cnt_q == LAST_CNT) begin
          if (!(cancelled_q || i_cancel)) begin
            i_rdata_d = mem_rdata;
            i_ready_d = 1'b1;
          end
          last_data_d = 1'b0;
          mem_en_d    = 1'b0;
          mem_wr_d    = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (stall_if && stall_mem && (conflict_q != 16'hFFFF))
      conflict_d = conflict_q + 16'd1;
  end

  assign i_rdata      = i_rdata_q;
  assign i_ready      = i_ready_q;
  assign d_rdata      = d_rdata_q;
  assign d_ready      = d_ready_q;
  assign mem_en       = mem_en_q;
  assign mem_wr       = mem_wr_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign conflict_cnt = conflict_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port unified instruction/data memory between the fetch stage (instruction port) and the memory stage (data port) of the 5-stage 16-bit CPU. It serialises accesses through a fixed-latency memory and holds each access stable for its full duration. It returns one-cycle completion pulses and drives the stall requests that freeze the pipeline while a port waits. It sits between `cpu` pipeline stages and the memory macro.

## Interface
- `ADDR_W`, 16, address width.
- `DATA_W`, 16, data width.
- `MEM_LAT`, 4, memory cycles per access (legal range 1..15).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch read request; level, held until `i_ready`.
- `i_addr`  in  ADDR_W  fetch address; stable while `i_req`.
- `i_cancel`  in  1  pulse; discard any pending or in-flight fetch (branch flush).
- `i_rdata`  out  DATA_W  fetched instruction; valid when `i_ready`.
- `i_ready`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  data request; level, held until `d_ready`.
- `d_wr`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; valid when `d_ready`.
- `d_ready`  out  1  one-cycle data completion pulse.
- `mem_en`  out  1  memory access active.
- `mem_wr`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid in the last cycle of an access.
- `stall_if`  out  1  `i_req & ~i_ready & ~i_cancel`; combinational.
- `stall_mem`  out  1  `d_req & ~d_ready`; combinational.
- `conflict_cnt`  out  16  saturating count of cycles with both ports waiting.

## Operation
- FSM states: IDLE, DATA, INST. Counter `cnt` is 4 bits.
- **IDLE arbitration**, registered:
  - A request is eligible only if its own ready is low this cycle.
  - A fetch is also ineligible if `i_cancel` is high this cycle.
  - Priority goes to DATA, except when the previous completed access was DATA and a fetch is eligible; then INST wins. This alternates under contention.
  - No eligible request: remain in IDLE.
- **On grant:**
  - Latch the address, `wr` and `wdata` into the `mem_*` registers.
  - Set `cnt` to 0.
  - Enter DATA or INST.
- **DATA/INST states:**
  - Hold `mem_en` = 1 and keep the `mem_*` registers stable.
  - `mem_wr` = `d_wr` (latched) in DATA; 0 in INST.
  - Increment `cnt` each cycle.
  - When `cnt == MEM_LAT-1`: capture `mem_rdata` into `d_rdata` or `i_rdata` (reads only), set that port's ready for the next cycle, and return to IDLE.
- **Stores:** `d_ready` pulses with the same timing as a load. `d_rdata` keeps its previous value.
- **Fetch cancel:**
  - `i_cancel` during INST: the memory access runs to completion, because memory cannot be aborted. A `cancelled` flag is set; at completion, `i_ready` is suppressed and `i_rdata` is not updated.
  - `i_cancel` in IDLE: no fetch is granted that cycle.
  - `i_cancel` during DATA: no effect on the data access.
- **`conflict_cnt`:** increments on every cycle where `stall_if & stall_mem`, saturating at 0xFFFF.
- **Reset** (asynchronous, any state, including mid-access):
  - State goes to IDLE; `cnt`, `cancelled` and `conflict_cnt` go to 0.
  - All registered outputs go to 0: `mem_en`, `mem_wr`, `mem_addr`, `mem_wdata`, `i_rdata`, `d_rdata`, `i_ready`, `d_ready`.
  - The last-winner record is set to INST, so DATA has priority first.
  - The in-flight access is abandoned.

## Timing
- Cycle 0: request high, state IDLE. Cycles 1..MEM_LAT: `mem_en` high. Cycle MEM_LAT+1: ready pulse, state IDLE.
  - Request-to-ready latency is MEM_LAT+1 cycles.
- During the ready cycle, that port's request is ignored, because the requester drops it on the next edge. The other port may be granted in the same ready cycle.
  - Back-to-back throughput is therefore one access per MEM_LAT+1 cycles.
- `i_ready`/`d_ready` are never high in the same cycle as each other, and never high for more than one cycle.
- `mem_*` outputs never change while `mem_en` = 1, except in reset.
- Request ports are sampled only in IDLE. Address changes in other cycles are ignored.

## Test plan
All cases use MEM_LAT = 4.

- **Single load:** `d_req`=1, `d_wr`=0, `d_addr`=0x0040, memory returns 0xBEEF → `mem_en` high in cycles 1–4 with `mem_addr`=0x0040, `d_ready`=1 and `d_rdata`=0xBEEF in cycle 5, `stall_mem` high in cycles 0–4.
- **Store:** `d_wr`=1, `d_addr`=0x0010, `d_wdata`=0x1234 → `mem_wr`=1 and `mem_wdata`=0x1234 for 4 cycles, `d_ready` in cycle 5, `d_rdata` unchanged.
- **Contention:** `i_req` and `d_req` raised in the same cycle → DATA access first (`d_ready` in cycle 5), INST granted in cycle 5 (`i_ready` in cycle 10), `conflict_cnt` = 5.
- **Cancel mid-fetch:** fetch at 0x0100, `i_cancel` pulsed in cycle 2 → `mem_en` still high through cycle 4, no `i_ready`, `i_rdata` unchanged.
- **Reset mid-access:** `rst` asserted in cycle 2 of a load → `mem_en`=0 immediately (no clock edge needed), state IDLE, no `d_ready`, `conflict_cnt`=0.
- **Saturation:** hold both ports waiting for more than 65535 cycles (or force the counter to 0xFFFE) → `conflict_cnt` stays at 0xFFFF.
